// File: rtl/add_serial_feeder_pkg.sv
// Shared types and constants for the serial-adder operand feeder.
package add_serial_pkg;

  localparam int ADD_W       = 8;
  localparam int ADD_LATENCY = 12;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_RELEASE = 3'd4,
    S_GAP     = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/add_serial_feeder_op_fifo.sv
// Small synchronous operand FIFO; the head entry is always visible and never
// bypassed from a same-cycle push.
module op_fifo
  import add_serial_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 2 * ADD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          full_s;
  logic          do_push_s;
  logic          do_pop_s;

  assign full_s    = (count_q == CW'(DEPTH));
  assign empty_o   = (count_q == {CW{1'b0}});
  assign do_push_s = push_i && !full_s;
  assign do_pop_s  = pop_i && !empty_o;
  assign head_o    = mem_q[rd_q];
  assign count_o   = count_q;

  // Storage, pointers (wrap naturally since DEPTH is a power of two) and count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {W{1'b0}};
      end
      wr_q    <= {PW{1'b0}};
      rd_q    <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_q <= rd_q + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/add_serial_feeder.sv
// Sequences buffered (a, b) pairs into the serial adder one at a time and
// returns each captured sum on a valid/ready result port.
module add_serial_feeder
  import add_serial_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int LATENCY = ADD_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ADD_W-1:0] in_a,
  input  logic [ADD_W-1:0] in_b,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_en,
  input  logic [ADD_W-1:0] add_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ADD_W-1:0] res_data,
  output logic             busy
);

  localparam int FCW   = $clog2(DEPTH) + 1;
  localparam int CNT_W = $clog2(LATENCY);
  // Last counter value seen in S_WAIT; yields LATENCY-2 wait cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 3);

  feeder_state_t      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [ADD_W-1:0]   add_a_q;
  logic [ADD_W-1:0]   add_b_q;
  logic               add_en_q;
  logic               res_valid_q;
  logic [ADD_W-1:0]   res_data_q;
  logic               busy_q;

  logic [2*ADD_W-1:0] fifo_head_s;
  logic [FCW-1:0]     fifo_count_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               launch_s;

  assign in_ready = (fifo_count_s != FCW'(DEPTH));
  assign push_s   = in_valid && in_ready;
  // Never launch while an unaccepted result would be overwritten at capture.
  assign launch_s = (state_q == S_IDLE) && !fifo_empty_s && (!res_valid_q || res_ready);

  op_fifo #(
    .DEPTH (DEPTH),
    .W     (2 * ADD_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push_s),
    .pop_i   (launch_s),
    .data_i  ({in_a, in_b}),
    .head_o  (fifo_head_s),
    .count_o (fifo_count_s),
    .empty_o (fifo_empty_s)
  );

  // Sequencer FSM with registered adder controls, result register and busy flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      add_a_q     <= {ADD_W{1'b0}};
      add_b_q     <= {ADD_W{1'b0}};
      add_en_q    <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= {ADD_W{1'b0}};
      busy_q      <= 1'b0;
    end else begin
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (launch_s) begin
            add_a_q  <= fifo_head_s[2*ADD_W-1:ADD_W];
            add_b_q  <= fifo_head_s[ADD_W-1:0];
            add_en_q <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          add_en_q <= 1'b0;
          cnt_q    <= {CNT_W{1'b0}};
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          res_data_q  <= add_out;
          res_valid_q <= 1'b1;
          add_en_q    <= 1'b1;
          state_q     <= S_RELEASE;
        end
        S_RELEASE: begin
          add_en_q <= 1'b0;
          state_q  <= S_GAP;
        end
        S_GAP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          add_en_q <= 1'b0;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_en    = add_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_add_serial_feeder.sv
// Scoreboard bench for add_serial_feeder driven against a behavioural serial adder.
module tb_add_serial_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       res_ready = 1'b0;
  logic [7:0] in_a = 8'h00;
  logic [7:0] in_b = 8'h00;
  logic [7:0] add_out;
  logic       in_ready;
  logic [7:0] add_a;
  logic [7:0] add_b;
  logic       add_en;
  logic       res_valid;
  logic [7:0] res_data;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  add_serial_feeder #(.DEPTH(4), .LATENCY(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_en    (add_en),
    .add_out   (add_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural adder: garbage on out while computing, sum once DONE (2..10 cycles after en).
  int         ad_st;
  int         ad_dly;
  logic [7:0] ad_a, ad_b;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ad_st   <= 0;
      ad_dly  <= 0;
      add_out <= 8'h00;
    end else begin
      case (ad_st)
        0: if (add_en) begin
             ad_st   <= 1;
             ad_dly  <= int'($urandom_range(2, 10));
             ad_a    <= add_a;
             ad_b    <= add_b;
             add_out <= 8'($urandom);
           end
        1: if (ad_dly <= 1) begin
             add_out <= 8'(ad_a + ad_b);
             ad_st   <= 2;
           end else begin
             ad_dly  <= ad_dly - 1;
             add_out <= 8'($urandom);
           end
        2: if (add_en) begin
             ad_st   <= 0;
             add_out <= 8'($urandom);
           end
        default: ad_st <= 0;
      endcase
    end
  end

  // Scoreboard and protocol monitor, sampled mid-cycle.
  logic [7:0] exp_q[$];
  int         en_cnt, launch_cyc, last_spacing, rel_cyc, rv_seen;
  logic       p_busy, p_rv, p_rr;
  logic [7:0] p_a, p_b, p_rd;
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      en_cnt       = 0;
      launch_cyc   = -100;
      last_spacing = 0;
      rel_cyc      = -100;
      rv_seen      = 0;
      p_busy       = 1'b0;
      p_rv         = 1'b0;
      p_rr         = 1'b0;
    end else begin
      if (in_valid && in_ready) exp_q.push_back(8'(in_a + in_b));
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
        else check("sb_result", 32'(res_data), 32'(exp_q.pop_front()));
      end
      if (p_busy && busy) begin
        check("add_a_stable", 32'(add_a), 32'(p_a));
        check("add_b_stable", 32'(add_b), 32'(p_b));
      end
      if (p_rv && !p_rr) begin
        check("rv_held", 32'(res_valid), 32'd1);
        check("res_data_stable", 32'(res_data), 32'(p_rd));
      end
      if (cyc == rel_cyc + 1) check("gap_en_low", 32'(add_en), 32'd0);
      if (add_en) begin
        en_cnt++;
        if (en_cnt % 2 == 1) begin
          last_spacing = cyc - launch_cyc;
          launch_cyc   = cyc;
          check("launch_spacing_min", 32'(last_spacing >= 15), 32'd1);
          check("busy_at_launch", 32'(busy), 32'd1);
        end else begin
          rel_cyc = cyc;
          check("release_latency", 32'(cyc - launch_cyc), 32'd12);
          check("rv_rises_at_release", 32'({p_rv, res_valid}), 32'b01);
        end
      end
      if (res_valid) rv_seen++;
      p_busy = busy;
      p_rv   = res_valid;
      p_rr   = res_ready;
      p_a    = add_a;
      p_b    = add_b;
      p_rd   = res_data;
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b, input bit rnd_rr);
    int n = 0;
    bit done = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!done && n < 300) begin
      if (rnd_rr) res_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input bit rnd_rr);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      res_ready = rnd_rr ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_rv_clear", 32'(res_valid), 32'd0);
  endtask

  task automatic wait_rv();
    int n = 0;
    while (!res_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rv_timeout", 32'(res_valid), 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int start_en, c0;
    idle_cycles(3);
    check("rst_add_en", 32'(add_en), 32'd0);
    check("rst_add_a", 32'(add_a), 32'd0);
    check("rst_add_b", 32'(add_b), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b1;
    idle_cycles(2);

    // Single operation, result held for inspection.
    res_ready = 1'b0;
    push(8'h12, 8'h34, 1'b0);
    wait_rv();
    check("single_sum", 32'(res_data), 32'h46);
    drain(1'b0);

    // FIFO fill with the adder busy.
    res_ready = 1'b1;
    push(8'h01, 8'h02, 1'b0);
    idle_cycles(2);
    for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom), 1'b0);
    check("fifo_full_in_ready", 32'(in_ready), 32'd0);
    c0 = cyc;
    push(8'hF0, 8'h20, 1'b0);
    check("fifth_stalled", 32'((cyc - c0) > 3), 32'd1);
    drain(1'b0);

    // Backpressure blocks the second launch.
    res_ready = 1'b0;
    start_en = en_cnt;
    push(8'hAA, 8'h55, 1'b0);
    push(8'h80, 8'h81, 1'b0);
    wait_rv();
    idle_cycles(20);
    check("bp_no_launch", 32'(en_cnt - start_en), 32'd2);
    check("bp_busy_low", 32'(busy), 32'd0);
    check("bp_rv_held", 32'(res_valid), 32'd1);
    res_ready = 1'b1;
    idle_cycles(1);
    res_ready = 1'b0;
    check("bp_launch_after_ready", 32'(add_en), 32'd1);
    drain(1'b0);

    // Wrap-around with random result backpressure.
    for (int i = 0; i < 10; i++) push(8'($urandom), 8'($urandom), 1'b1);
    drain(1'b1);

    // Back-to-back throughput.
    res_ready = 1'b1;
    push(8'h10, 8'h20, 1'b0);
    push(8'hFF, 8'h02, 1'b0);
    drain(1'b0);
    check("b2b_spacing", 32'(last_spacing), 32'd15);

    // Reset in the middle of S_WAIT with three pairs queued.
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'($urandom), 8'($urandom), 1'b0);
    idle_cycles(2);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_add_en", 32'(add_en), 32'd0);
    check("mid_rst_add_a", 32'(add_a), 32'd0);
    check("mid_rst_add_b", 32'(add_b), 32'd0);
    check("mid_rst_res_valid", 32'(res_valid), 32'd0);
    check("mid_rst_res_data", 32'(res_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    idle_cycles(1);
    rst = 1'b1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    idle_cycles(40);
    check("post_rst_no_result", 32'(rv_seen), 32'd0);
    check("post_rst_no_en", 32'(en_cnt), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/add_serial_feeder.md
# add_serial_feeder

Operand sequencer that sits directly upstream of the 8-bit serial adder `add_serial`. It buffers incoming (a, b) operand pairs in a small FIFO and drives the adder's `a`/`b`/`en` pins with one operation at a time. After a fixed latency it captures the adder's `out` bus and presents the result on a valid/ready port. It then pulses `en` again to return the adder from DONE to IDLE.

## Interface
- `DEPTH`, 4: operand FIFO entries; power of two, ≥2.
- `LATENCY`, 12: cycles from the launch `en` pulse to result capture; must cover the adder's worst-case path to DONE.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair offered.
- `in_ready`  out  1  FIFO can accept; `in_ready = (fifo_count != DEPTH)`.
- `in_a`, `in_b`  in  8  operands, taken when `in_valid && in_ready`.
- `add_a`, `add_b`  out  8  to adder `a`/`b`; held stable from launch until release.
- `add_en`  out  1  to adder `en`.
- `add_out`  in  8  from adder `out`.
- `res_valid`  out  1  result held.
- `res_ready`  in  1  consumer accepts.
- `res_data`  out  8  captured sum.
- `busy`  out  1  FSM not in S_IDLE.

## Operation
- Reset (`rst` low) forces all outputs to 0, the FIFO to empty, the FSM to S_IDLE and the wait counter to 0.
- FIFO:
  - Push when `in_valid && in_ready`.
  - Pop only in S_IDLE on a launch decision.
  - A simultaneous push and pop is legal.
  - When empty, a push is not bypassed to the pop in the same cycle.
  - Pointers wrap modulo DEPTH.
  - `fifo_count` runs 0..DEPTH.
- FSM states and transitions:
  - S_IDLE: if the FIFO is non-empty and (`!res_valid` or `res_ready`), pop the head into `add_a`/`add_b` and go to S_LAUNCH. Otherwise stay.
  - S_LAUNCH: `add_en = 1` for exactly this cycle; clear the counter; go to S_WAIT.
  - S_WAIT: increment the counter; at `LATENCY-2` go to S_CAPTURE.
  - S_CAPTURE: `res_data <= add_out`, `res_valid <= 1`; go to S_RELEASE.
  - S_RELEASE: `add_en = 1` (adder moves DONE→IDLE); go to S_GAP.
  - S_GAP: `add_en = 0`, so the adder idles one cycle; go to S_IDLE.
- `add_en` is low in every state except S_LAUNCH and S_RELEASE.
- Result port:
  - `res_valid` clears on `res_valid && res_ready`.
  - `res_data` is stable while `res_valid && !res_ready`.
  - The launch rule guarantees S_CAPTURE never overwrites an unaccepted result.
- `add_a`/`add_b` change only on the S_IDLE→S_LAUNCH edge.
- Widths: the counter is `$clog2(LATENCY)` bits. No arithmetic on data; the feeder does not compute or check sums.

## Timing
- Launch pulse at cycle L. Capture samples `add_out` on the edge ending cycle L+LATENCY-1, and `res_valid` rises at L+LATENCY.
- Release pulse at L+LATENCY, gap at L+LATENCY+1, S_IDLE at L+LATENCY+2.
- Back-to-back throughput is one operation per LATENCY+3 cycles.
- `in_valid` to `in_ready`: combinational from count only, with no dependence on `in_valid`.
- Reset mid-operation: outputs drop to 0 immediately and queued operands are discarded. The adder shares the reset net, so both restart in IDLE.
- FIFO full with a simultaneous pop: `in_ready` stays 0 that cycle because it is computed on the pre-pop count.

## Structure
- Shared package `add_serial_pkg`:
  - FSM state enum `feeder_state_t`: S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_RELEASE, S_GAP.
  - Data width constant `ADD_W = 8`.
  - Default `ADD_LATENCY = 12`.
- One sub-module, `op_fifo`: a parameterised DEPTH×16 synchronous FIFO with count, full and empty.
- The FSM, counter and result register live in the top module.

## Test plan
- Reset: drive `rst` low mid-S_WAIT with 3 queued pairs → all outputs 0, `in_ready = 1` next cycle, no `res_valid` after release.
- Single operation: push a=0x12, b=0x34 against a behavioural adder returning 0x46 at its DONE → `add_en` pulses at L and L+12, `res_data = 0x46`, `res_valid` at L+12.
- FIFO fill: push 5 pairs back-to-back with the adder busy → `in_ready` drops after the 4th, the 5th is stalled, and all 5 results emerge in order.
- Backpressure: hold `res_ready = 0` with 2 pairs queued → the second launch does not start. `res_data` stays stable; after `res_ready` pulses, the next `add_en` appears within 1 cycle.
- Wrap-around: 10 operations with random `res_ready` → pointers wrap twice, results match the pushed order, and `add_a`/`add_b` never change while `busy` is high outside S_IDLE.
- Gap: two back-to-back operations → `add_en` is 0 in the cycle after each release pulse, and the launches are exactly 15 cycles apart.
